// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad number-entry block.
//   - key codes for the non-digit keys the entry logic reacts to
//   - FSM state encoding
//   - is_digit helper used to classify scanner key codes
package keypad_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_CONV  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_to_bin.sv
// Combinational BCD to unsigned binary converter.
//   bcd : NUM_DIGITS packed BCD digits, [3:0] = units
//   bin : sum of d_i * 10^i at VALUE_W bits
// Horner form (acc*10 + d, MS digit first) keeps every partial sum below
// 10^NUM_DIGITS, so nothing is truncated when VALUE_W holds the maximum.
module bcd_to_bin #(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 14
) (
  input  logic [4*NUM_DIGITS-1:0] bcd,
  output logic [VALUE_W-1:0]      bin
);

  logic [VALUE_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc = VALUE_W'(acc * VALUE_W'(10)) + VALUE_W'(bcd[4*i +: 4]);
    end
    bin = acc;
  end

endmodule

// File: rtl/keypad_number_entry.sv
// Keypad number entry: collects decimal digit keys into a BCD register,
// converts to binary on ENTER and offers the result over valid/ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   key_code, key_valid scanner key code and one-cycle strobe
//   digits              BCD digits for display, [3:0] = units
//   digit_count         significant digits entered (0..NUM_DIGITS)
//   value, value_valid  binary operand and its valid flag
//   value_ready         consumer accept
//   key_drop            one-cycle pulse when a key is ignored
module keypad_number_entry
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              key_code,
  input  logic                    key_valid,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [2:0]              digit_count,
  output logic [VALUE_W-1:0]      value,
  output logic                    value_valid,
  input  logic                    value_ready,
  output logic                    key_drop
);

  state_t                  state_q;
  state_t                  state_nxt;
  logic [4*NUM_DIGITS-1:0] digits_p0;
  logic [2:0]              count_p0;
  logic [VALUE_W-1:0]      value_p1;
  logic [VALUE_W-1:0]      bin_p0;
  logic                    drop_q;
  logic                    accept;
  logic                    clear_key;

  assign accept    = (state_q == ST_HOLD) && value_ready;
  assign clear_key = key_valid && (key_code == KEY_CLEAR);

  bcd_to_bin #(
    .NUM_DIGITS (NUM_DIGITS),
    .VALUE_W    (VALUE_W)
  ) u_bcd_to_bin (
    .bcd (digits_p0),
    .bin (bin_p0)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_ENTRY;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_ENTRY: if (key_valid && key_code == KEY_ENTER) state_nxt = ST_CONV;
      ST_CONV:  state_nxt = clear_key ? ST_ENTRY : ST_HOLD;
      ST_HOLD:  if (accept || clear_key) state_nxt = ST_ENTRY;
      default:  state_nxt = ST_ENTRY;
    endcase
  end

  always_comb begin
    value_valid = (state_q == ST_HOLD);
  end

  // Stage p0: digit entry register and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_p0 <= '0;
      count_p0  <= '0;
      drop_q    <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (state_q == ST_ENTRY) begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            if (count_p0 == 3'(NUM_DIGITS)) begin
              drop_q <= 1'b1;
            end else if (!(key_code == 4'd0 && count_p0 == 3'd0)) begin
              // Leading zeros are swallowed so count stays "significant digits".
              digits_p0 <= {digits_p0[4*NUM_DIGITS-5:0], key_code};
              count_p0  <= count_p0 + 3'd1;
            end
          end else if (key_code == KEY_BKSP) begin
            digits_p0 <= digits_p0 >> 4;
            if (count_p0 != 3'd0) count_p0 <= count_p0 - 3'd1;
          end else if (key_code == KEY_CLEAR) begin
            digits_p0 <= '0;
            count_p0  <= '0;
          end
        end
      end else begin
        // CONV/HOLD: only CLEAR is honoured; acceptance and CLEAR end identically.
        if (accept || clear_key) begin
          digits_p0 <= '0;
          count_p0  <= '0;
        end
        if (key_valid && key_code != KEY_CLEAR) drop_q <= 1'b1;
      end
    end
  end

  // Stage p1: conversion result, loaded only in CONV
  always_ff @(posedge clk) begin
    if (rst)                     value_p1 <= '0;
    else if (state_q == ST_CONV) value_p1 <= bin_p0;
  end

  assign digits      = digits_p0;
  assign digit_count = count_p0;
  assign value       = value_p1;
  assign key_drop    = drop_q;

endmodule
